// File: rtl/ladybird_serial_adder_pkg.sv
// Shared types and helpers for the ladybird digit-serial adder.
package ladybird_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned num_digits);
    int unsigned w;
    w = $clog2(num_digits);
    if (w < 1) w = 1;
    return w;
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/ladybird_serial_adder_if.sv
// Operand/result handshake bundle for ladybird_serial_adder.
// in_sub exists only when LADYBIRD_ADDSUB_EN is defined.
interface ladybird_serial_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_c;
`ifdef LADYBIRD_ADDSUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_c;
  logic             out_ovf;

  modport master (
`ifdef LADYBIRD_ADDSUB_EN
    output in_sub,
`endif
    output in_valid, in_x, in_y, in_c, out_ready,
    input  in_ready, out_valid, out_q, out_c, out_ovf
  );

  modport slave (
`ifdef LADYBIRD_ADDSUB_EN
    input  in_sub,
`endif
    input  in_valid, in_x, in_y, in_c, out_ready,
    output in_ready, out_valid, out_q, out_c, out_ovf
  );

endinterface

// File: rtl/ladybird_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from a chain of full-adder cells.
module ladybird_digit_adder
  import ladybird_serial_adder_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_s,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic w_c;

  // o_c_msb is the carry entering the top bit, needed for signed overflow.
  always_comb begin
    w_c     = i_cin;
    o_s     = '0;
    o_c_msb = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) o_c_msb = w_c;
      {w_c, o_s[i]} = full_add(i_a[i], i_b[i], w_c);
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/ladybird_serial_adder.sv
// Digit-serial adder: WIDTH-bit x + y + carry, DIGIT bits per clock.
// Optional LADYBIRD_ADDSUB_EN adds in_sub for x - y.
module ladybird_serial_adder
  import ladybird_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  ladybird_serial_adder_if.slave  bus
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
  localparam int unsigned CW         = cnt_width(NUM_DIGITS);
  localparam logic [CW-1:0] LAST     = CW'(NUM_DIGITS - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("ladybird_serial_adder: DIGIT must divide WIDTH");
  end

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_q;
  logic             r_c;
  logic             r_ovf;
  logic             r_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_y_in;
  logic             w_c_in;
  logic [DIGIT-1:0] w_xd;
  logic [DIGIT-1:0] w_yd;
  logic [DIGIT-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;

  assign w_in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;

`ifdef LADYBIRD_ADDSUB_EN
  // Subtraction as x + ~y + 1; the overflow rule is then the same as for add.
  assign w_y_in = bus.in_sub ? ~bus.in_y : bus.in_y;
  assign w_c_in = bus.in_sub ? 1'b1 : bus.in_c;
`else
  assign w_y_in = bus.in_y;
  assign w_c_in = bus.in_c;
`endif

  always_comb begin
    w_xd = '0;
    w_yd = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (r_cnt == CW'(d)) begin
        w_xd = r_x[d*DIGIT +: DIGIT];
        w_yd = r_y[d*DIGIT +: DIGIT];
      end
    end
  end

  ladybird_digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a     (w_xd),
    .i_b     (w_yd),
    .i_cin   (r_carry),
    .o_s     (w_s),
    .o_cout  (w_cout),
    .o_c_msb (w_cmsb)
  );

  // Control FSM and datapath registers; an accept overrides the DONE->IDLE step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_q     <= '0;
      r_c     <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        RUN: begin
          for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (r_cnt == CW'(d)) r_q[d*DIGIT +: DIGIT] <= w_s;
          end
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_c     <= w_cout;
            r_ovf   <= w_cmsb ^ w_cout;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_x     <= bus.in_x;
        r_y     <= w_y_in;
        r_carry <= w_c_in;
        r_cnt   <= '0;
        r_state <= RUN;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_q     = r_q;
  assign bus.out_c     = r_c;
  assign bus.out_ovf   = r_ovf;

endmodule
